// File: rtl/rn52_pkg.sv
// Shared constants and state types for the RN52 command responder.
package rn52_pkg;

  localparam logic [7:0] CR = 8'h0D;

  // Byte 0 is transmitted first.
  localparam logic [3:0][7:0] AOK_BYTES = {8'h0D, 8'h4B, 8'h4F, 8'h41};
  localparam logic [3:0][7:0] ERR_BYTES = {8'h0D, 8'h52, 8'h52, 8'h45};

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {COLLECT, OVERFLOW} col_state_t;
  typedef enum logic {IDLE, SEND} tx_state_t;
  typedef enum logic {RESP_AOK, RESP_ERR} resp_kind_t;

  function automatic logic [7:0] resp_byte(resp_kind_t kind, logic [1:0] idx);
    return (kind == RESP_ERR) ? ERR_BYTES[idx] : AOK_BYTES[idx];
  endfunction

endpackage

// File: rtl/rn52_responder_if.sv
// Serial lines and command status of the RN52 responder.
interface rn52_responder_if;
  logic       RX;
  logic       TX;
  logic       cmd_rdy;
  logic       cmd_err;
  logic [4:0] cmd_len;
  logic [7:0] cmd_first;

  modport slave  (input RX, output TX, cmd_rdy, cmd_err, cmd_len, cmd_first);
  modport master (output RX, input TX, cmd_rdy, cmd_err, cmd_len, cmd_first);
endinterface

// File: rtl/rn52_uart_tx.sv
// 8N1 serial transmitter; a new byte can be loaded in the last clk of the
// current stop bit so consecutive bytes leave with no idle gap.
module rn52_uart_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       frame_end
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          load;

  // bit_cnt: 0 = start bit, 1..8 = data, 9 = stop bit
  assign frame_end = busy && (bit_cnt == 4'd9) && (baud_cnt == '0);
  assign load      = start && (!busy || frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (load) begin
      tx       <= 1'b0;
      busy     <= 1'b1;
      baud_cnt <= FULL_BIT;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data};
    end else if (busy) begin
      if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else if (bit_cnt == 4'd9) begin
        busy <= 1'b0;
      end else begin
        tx       <= shreg[0];
        shreg    <= {1'b1, shreg[8:1]};
        bit_cnt  <= bit_cnt + 1'b1;
        baud_cnt <= FULL_BIT;
      end
    end
  end

endmodule

// File: rtl/rn52_responder.sv
// RN52-style command responder: receives CR-terminated commands over UART
// and answers "AOK\r" or "ERR\r".
//   state     | meaning
//   RX_IDLE   | waiting for falling edge on RX
//   RX_START  | half-bit wait, start bit re-checked
//   RX_DATA   | sampling 8 data bits at bit centres
//   RX_STOP   | sampling stop bit, byte delivered
//   COLLECT   | counting command bytes
//   OVERFLOW  | command too long or framing error, waiting for CR
//   IDLE      | transmitter quiet
//   SEND      | response bytes being sent
module rn52_responder
  import rn52_pkg::*;
#(
  parameter int BAUD_DIV = 434,
  parameter int MAX_CMD  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rn52_responder_if.slave  bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2 - 1);
  localparam logic [4:0]    MAX_CNT  = 5'(MAX_CMD);

  logic          rx_s1, rx_s2, rx_d;
  rx_state_t     rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_sh, rx_sh_nxt;
  logic          rx_done, rx_ferr;

  col_state_t    col_state, col_state_nxt;
  logic [4:0]    cnt, cnt_nxt;
  logic [7:0]    first_stage, first_stage_nxt;
  logic [4:0]    cmd_len_q, len_nxt;
  logic [7:0]    cmd_first_q, first_nxt;
  logic          cmd_rdy_q, rdy_nxt;
  logic          cmd_err_q, err_nxt;

  tx_state_t     tx_state, tx_state_nxt;
  logic [2:0]    byte_idx, byte_idx_nxt;
  resp_kind_t    cur_kind, cur_kind_nxt;
  logic          pend_valid, pend_valid_nxt;
  resp_kind_t    pend_kind, pend_kind_nxt;
  logic          issue, issue_taken;
  resp_kind_t    issue_kind;
  logic          tx_start, tx_busy, tx_frame_end, tx_ready;
  logic [7:0]    tx_data;

  // Receiver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= bus.RX;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_sh    <= rx_sh_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_done      = 1'b0;
    rx_ferr      = 1'b0;
    if (rx_state != RX_IDLE && rx_cnt != '0) begin
      rx_cnt_nxt = rx_cnt - 1'b1;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_state_nxt = RX_START;
            rx_cnt_nxt   = HALF_BIT;
          end
        end
        RX_START: begin
          rx_cnt_nxt   = FULL_BIT;
          rx_bit_nxt   = '0;
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          rx_cnt_nxt = FULL_BIT;
          rx_sh_nxt  = {rx_s2, rx_sh[7:1]};
          rx_bit_nxt = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
        RX_STOP: begin
          rx_done      = 1'b1;
          rx_ferr      = !rx_s2;
          rx_state_nxt = RX_IDLE;
        end
        default: rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  // Collector; the first byte is staged so a rejected command leaves cmd_first alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_state   <= COLLECT;
      cnt         <= '0;
      first_stage <= '0;
      cmd_len_q   <= '0;
      cmd_first_q <= '0;
      cmd_rdy_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      col_state   <= col_state_nxt;
      cnt         <= cnt_nxt;
      first_stage <= first_stage_nxt;
      cmd_len_q   <= len_nxt;
      cmd_first_q <= first_nxt;
      cmd_rdy_q   <= rdy_nxt;
      cmd_err_q   <= err_nxt;
    end
  end

  always_comb begin
    col_state_nxt   = col_state;
    cnt_nxt         = cnt;
    first_stage_nxt = first_stage;
    len_nxt         = cmd_len_q;
    first_nxt       = cmd_first_q;
    rdy_nxt         = 1'b0;
    err_nxt         = 1'b0;
    if (rx_done) begin
      if (rx_ferr) begin
        col_state_nxt = OVERFLOW;
      end else if (rx_sh == CR) begin
        cnt_nxt = '0;
        if (col_state == OVERFLOW) begin
          err_nxt       = 1'b1;
          col_state_nxt = COLLECT;
        end else if (cnt != '0) begin
          rdy_nxt   = 1'b1;
          len_nxt   = cnt;
          first_nxt = first_stage;
        end
      end else if (col_state == COLLECT) begin
        if (cnt >= MAX_CNT) begin
          col_state_nxt = OVERFLOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == '0) first_stage_nxt = rx_sh;
        end
      end
    end
  end

  // Response sequencer with a single pending slot
  assign issue      = cmd_rdy_q | cmd_err_q;
  assign issue_kind = cmd_err_q ? RESP_ERR : RESP_AOK;
  assign tx_ready   = !tx_busy || tx_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= IDLE;
      byte_idx   <= '0;
      cur_kind   <= RESP_AOK;
      pend_valid <= 1'b0;
      pend_kind  <= RESP_AOK;
    end else begin
      tx_state   <= tx_state_nxt;
      byte_idx   <= byte_idx_nxt;
      cur_kind   <= cur_kind_nxt;
      pend_valid <= pend_valid_nxt;
      pend_kind  <= pend_kind_nxt;
    end
  end

  always_comb begin
    tx_state_nxt   = tx_state;
    byte_idx_nxt   = byte_idx;
    cur_kind_nxt   = cur_kind;
    pend_valid_nxt = pend_valid;
    pend_kind_nxt  = pend_kind;
    tx_start       = 1'b0;
    tx_data        = resp_byte(cur_kind, byte_idx[1:0]);
    issue_taken    = 1'b0;
    case (tx_state)
      IDLE: begin
        if (issue) begin
          tx_start     = 1'b1;
          tx_data      = resp_byte(issue_kind, 2'd0);
          cur_kind_nxt = issue_kind;
          byte_idx_nxt = 3'd1;
          tx_state_nxt = SEND;
          issue_taken  = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_idx != 3'd4) begin
            tx_start     = 1'b1;
            byte_idx_nxt = byte_idx + 3'd1;
          end else if (pend_valid) begin
            tx_start       = 1'b1;
            tx_data        = resp_byte(pend_kind, 2'd0);
            cur_kind_nxt   = pend_kind;
            byte_idx_nxt   = 3'd1;
            pend_valid_nxt = 1'b0;
          end else if (issue) begin
            tx_start     = 1'b1;
            tx_data      = resp_byte(issue_kind, 2'd0);
            cur_kind_nxt = issue_kind;
            byte_idx_nxt = 3'd1;
            issue_taken  = 1'b1;
          end else begin
            tx_state_nxt = IDLE;
          end
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
    // A response that finds the pending slot occupied is dropped
    if (issue && !issue_taken && !pend_valid_nxt) begin
      pend_valid_nxt = 1'b1;
      pend_kind_nxt  = issue_kind;
    end
  end

  rn52_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (tx_start),
    .data      (tx_data),
    .tx        (bus.TX),
    .busy      (tx_busy),
    .frame_end (tx_frame_end)
  );

  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.cmd_first = cmd_first_q;

endmodule

// File: tb/tb_rn52_responder.sv
// Scoreboard bench for rn52_responder: a UART monitor and a command-pulse
// monitor pop expected values queued by the directed stimulus.
module tb_rn52_responder;

  localparam int BAUD = 16;

  typedef struct {
    bit         is_err;
    logic [4:0] len;
    logic [7:0] first;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   rst_events = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulse_cyc = 0;
  int   tx_start_cnt = 0;

  logic [7:0] exp_tx[$];
  evt_t       exp_evt[$];
  int         tx_starts[$];

  rn52_responder_if bus();

  rn52_responder #(.BAUD_DIV(BAUD), .MAX_CMD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_events <= rst_events + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.RX = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      tick(BAUD);
    end
    bus.RX = stop_bit;
    tick(BAUD);
    bus.RX = 1'b1;
  endtask

  task automatic send_cmd(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    send_byte(8'h0D, 1'b1);
  endtask

  task automatic push_evt(input bit is_err, input logic [4:0] len, input logic [7:0] first);
    evt_t e;
    e.is_err = is_err;
    e.len    = len;
    e.first  = first;
    exp_evt.push_back(e);
  endtask

  task automatic push_aok();
    exp_tx.push_back(8'h41); exp_tx.push_back(8'h4F);
    exp_tx.push_back(8'h4B); exp_tx.push_back(8'h0D);
  endtask

  task automatic push_err();
    exp_tx.push_back(8'h45); exp_tx.push_back(8'h52);
    exp_tx.push_back(8'h52); exp_tx.push_back(8'h0D);
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 4000;
    while ((exp_tx.size() != 0 || exp_evt.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({name, "_timeout"}, 32'(budget == 0), 32'd0);
    tick(20);
  endtask

  // UART monitor on TX
  initial begin : tx_mon
    logic [7:0] b;
    logic       stop_b;
    int         rst_snap;
    forever begin
      @(negedge clk);
      if (rst_n && bus.TX === 1'b0) begin
        tx_starts.push_back(cyc);
        tx_start_cnt++;
        rst_snap = rst_events;
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = bus.TX;
        end
        repeat (BAUD) @(negedge clk);
        stop_b = bus.TX;
        if (rst_events == rst_snap) begin
          if (exp_tx.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_unexpected_byte: got 0x%0h, expected no byte", b);
          end else begin
            chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            chk("tx_stop_bit", 32'(stop_b), 32'd1);
          end
        end
      end
    end
  end

  // Command pulse monitor
  initial begin : evt_mon
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.cmd_rdy === 1'b1 || bus.cmd_err === 1'b1)) begin
        pulse_cyc = cyc;
        chk("rdy_err_exclusive", 32'(bus.cmd_rdy & bus.cmd_err), 32'd0);
        if (exp_evt.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: got rdy=%0b err=%0b, expected none", bus.cmd_rdy, bus.cmd_err);
        end else begin
          e = exp_evt.pop_front();
          chk("pulse_is_err", 32'(bus.cmd_err), 32'(e.is_err));
          chk("cmd_len", 32'(bus.cmd_len), 32'(e.len));
          chk("cmd_first", 32'(bus.cmd_first), 32'(e.first));
        end
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no completion, expected finish within 60000 clks");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int low_cnt;
    int base;
    int budget;
    bus.RX = 1'b1;
    rst_n  = 1'b0;
    tick(3);
    chk("rst_tx", 32'(bus.TX), 32'd1);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    chk("rst_cmd_len", 32'(bus.cmd_len), 32'd0);
    chk("rst_cmd_first", 32'(bus.cmd_first), 32'd0);
    rst_n = 1'b1;
    tick(10);

    // basic accepted command and response timing
    tx_starts.delete();
    push_evt(1'b0, 5'd5, 8'h53);
    push_aok();
    send_cmd("S|,01");
    wait_idle("t_aok");
    chk("aok_byte_count", 32'(tx_starts.size()), 32'd4);
    chk("aok_first_start_latency", 32'(tx_starts[0] - pulse_cyc), 32'd1);
    chk("aok_span", 32'(tx_starts[3] - tx_starts[0]), 32'(30 * BAUD));

    // overflow then a good command
    push_evt(1'b1, 5'd5, 8'h53);
    push_err();
    push_evt(1'b0, 5'd2, 8'h41);
    push_aok();
    for (int i = 0; i < 17; i++) send_byte(8'h41, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_cmd("AT");
    wait_idle("t_ovf");

    // lone CR is ignored
    send_byte(8'h0D, 1'b1);
    low_cnt = 0;
    for (int i = 0; i < 50 * BAUD; i++) begin
      @(negedge clk);
      if (bus.TX !== 1'b1) low_cnt++;
    end
    chk("lone_cr_tx_low_clks", 32'(low_cnt), 32'd0);

    // second command finishes during the first response
    tx_starts.delete();
    push_evt(1'b0, 5'd3, 8'h41);
    push_aok();
    push_evt(1'b0, 5'd3, 8'h41);
    push_aok();
    send_cmd("AT+");
    send_cmd("AT-");
    wait_idle("t_b2b");
    chk("b2b_byte_count", 32'(tx_starts.size()), 32'd8);
    chk("b2b_span", 32'(tx_starts[7] - tx_starts[0]), 32'(70 * BAUD));

    // framing error, then glitch rejection
    push_evt(1'b1, 5'd3, 8'h41);
    push_err();
    send_byte(8'h55, 1'b0);
    bus.RX = 1'b1;
    tick(2 * BAUD);
    send_byte(8'h0D, 1'b1);
    wait_idle("t_ferr");
    bus.RX = 1'b0;
    tick(4);
    bus.RX = 1'b1;
    tick(3 * BAUD);
    push_evt(1'b0, 5'd2, 8'h41);
    push_aok();
    send_cmd("AT");
    wait_idle("t_glitch");

    // reset during the second response byte
    base = tx_start_cnt;
    push_evt(1'b0, 5'd2, 8'h41);
    exp_tx.push_back(8'h41);
    send_cmd("AT");
    budget = 3000;
    while (tx_start_cnt < base + 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("reset_wait_timeout", 32'(budget == 0), 32'd0);
    tick(3 * BAUD);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(bus.TX), 32'd1);
    chk("midrst_cmd_len", 32'(bus.cmd_len), 32'd0);
    chk("midrst_cmd_first", 32'(bus.cmd_first), 32'd0);
    chk("midrst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    tick(5);
    exp_tx.delete();
    chk("midrst_evt_consumed", 32'(exp_evt.size()), 32'd0);
    rst_n = 1'b1;
    tick(12 * BAUD);
    push_evt(1'b0, 5'd2, 8'h41);
    push_aok();
    send_cmd("AT");
    wait_idle("t_after_rst");

    chk("final_tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    chk("final_evt_queue_empty", 32'(exp_evt.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
